// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
//   Modulo-N up/down counter. This is the base counting element for clock
//   dividers and multi-digit counters. It supports a run-time direction,
//   synchronous clear, and a range-checked parallel load. It also provides a
//   combinational terminal count for cascading and registered pulses for
//   wrap and bad-load events.
//
// Parameters
//   WIDTH     counter width, 1..16
//   MODULUS   count modulus N, 2..2**WIDTH; q spans 0..N-1
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   en        count enable (cascade carry-in)
//   dir       1 = up, 0 = down
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load
//   load_val  value written on load
//   q         registered count value
//   tc        terminal count: en & (dir ? q==N-1 : q==0), zero latency
//   wrap      1-cycle pulse aligned with the q value produced by a wrap
//   load_err  1-cycle pulse aligned with q after an out-of-range load
// ---------------------------------------------------------------------------
module modn_updown_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   // Reject illegal configurations while the design is being elaborated.
   if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
      $error("modn_updown_counter: illegal WIDTH/MODULUS combination");
   end

   // N is compared using WIDTH+1 bits, so MODULUS == 2**WIDTH is representable.
   // N-1 always fits in WIDTH bits.
   localparam logic [WIDTH:0]   N_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             load_err_next;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (q == Q_MAX);
   assign at_zero = (q == '0);

   // tc is gated by en only. It is not gated by clr or load, so a downstream
   // stage sees the carry without any extra logic depth.
   assign tc = en & (dir ? at_max : at_zero);

   always_comb begin
      q_next        = q;
      wrap_next     = 1'b0;
      load_err_next = 1'b0;
      if (clr) begin
         q_next = '0;
      end else if (load) begin
         if ({1'b0, load_val} < N_EXT) begin
            q_next = load_val;
         end else begin
            // Clamp to 0 so that q can never hold a value >= N.
            q_next        = '0;
            load_err_next = 1'b1;
         end
      end else if (en) begin
         if (dir) begin
            if (at_max) begin
               q_next    = '0;
               wrap_next = 1'b1;
            end else begin
               q_next = q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               q_next    = Q_MAX;
               wrap_next = 1'b1;
            end else begin
               q_next = q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         wrap     <= wrap_next;
         load_err <= load_err_next;
      end
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_updown_counter
//   Directed bench. It uses a default mod-6 instance (u_dut), a two-stage
//   mod-6 cascade (u_c1 -> u_c2), and a WIDTH=4/MODULUS=16 instance (u_w16).
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at the same point.
// ---------------------------------------------------------------------------
module tb_modn_updown_counter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic       en = 0, dir = 1, clr = 0, load = 0;
   logic [2:0] load_val = '0;
   logic [2:0] q;
   logic       tc, wrap, load_err;

   // cascade
   logic       c_en = 0;
   logic [2:0] q1, q2;
   logic       tc1, tc2, wrap1, wrap2, lerr1, lerr2;

   // WIDTH=4, MODULUS=16
   logic       w_en = 0, w_dir = 1, w_clr = 0, w_load = 0;
   logic [3:0] w_load_val = '0;
   logic [3:0] w_q;
   logic       w_tc, w_wrap, w_load_err;

   modn_updown_counter #(.WIDTH(3), .MODULUS(6)) u_dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err));

   modn_updown_counter #(.WIDTH(3), .MODULUS(6)) u_c1 (
      .clk(clk), .reset(reset), .en(c_en), .dir(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(3'd0), .q(q1), .tc(tc1), .wrap(wrap1), .load_err(lerr1));

   modn_updown_counter #(.WIDTH(3), .MODULUS(6)) u_c2 (
      .clk(clk), .reset(reset), .en(tc1), .dir(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(3'd0), .q(q2), .tc(tc2), .wrap(wrap2), .load_err(lerr2));

   modn_updown_counter #(.WIDTH(4), .MODULUS(16)) u_w16 (
      .clk(clk), .reset(reset), .en(w_en), .dir(w_dir), .clr(w_clr), .load(w_load),
      .load_val(w_load_val), .q(w_q), .tc(w_tc), .wrap(w_wrap), .load_err(w_load_err));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int up_seq [14] = '{1,2,3,4,5,0,1,2,3,4,5,0,1,2};
   int dn_seq [7]  = '{5,4,3,2,1,0,5};

   initial begin
      // ---- reset state
      step();
      check("rst_q", q, 0);
      check("rst_wrap", wrap, 0);
      check("rst_load_err", load_err, 0);
      check("rst_w16_q", w_q, 0);
      reset = 0;

      // ---- 1: up count, 14 clks
      en = 1; dir = 1;
      for (int i = 0; i < 14; i++) begin
         step();
         check("up_q", q, up_seq[i]);
         check("up_wrap", wrap, (up_seq[i] == 0) ? 1 : 0);
         check("up_tc", tc, (up_seq[i] == 5) ? 1 : 0);
         check("up_range", (q < 6) ? 1 : 0, 1);
      end

      // ---- 2: clear, then down count from 0
      clr = 1;
      step();
      check("clr_q", q, 0);
      check("clr_wrap", wrap, 0);
      clr = 0; dir = 0;
      #1 check("dn_tc_at0", tc, 1);
      for (int i = 0; i < 7; i++) begin
         step();
         check("dn_q", q, dn_seq[i]);
         check("dn_wrap", wrap, (i == 0 || i == 6) ? 1 : 0);
         check("dn_tc", tc, (dn_seq[i] == 0) ? 1 : 0);
      end

      // ---- 3: loads
      en = 0; load = 1; load_val = 3'd4;
      step();
      check("ld4_q", q, 4);
      check("ld4_err", load_err, 0);
      load_val = 3'd7;
      step();
      check("ld7_q", q, 0);
      check("ld7_err", load_err, 1);
      load_val = 3'd6;             // exactly N: out of range
      step();
      check("ld6_q", q, 0);
      check("ld6_err", load_err, 1);
      load = 0;
      step();
      check("ld_err_pulse", load_err, 0);
      check("idle_q", q, 0);
      load = 1; load_val = 3'd7;
      step();
      check("ld7b_err", load_err, 1);
      clr = 1;                     // clr beats an out-of-range load
      step();
      check("clrld_q", q, 0);
      check("clrld_err", load_err, 0);
      clr = 0; load_val = 3'd5; en = 1; dir = 1;   // load beats en
      step();
      check("ld_en_q", q, 5);
      check("ld_en_wrap", wrap, 0);
      check("ld_en_err", load_err, 0);

      // ---- 4: dir toggle at q=5, then async reset at q=3
      load = 0; dir = 0;
      step();
      check("dirtog_q", q, 4);
      check("dirtog_wrap", wrap, 0);
      step();
      check("pre_rst_q", q, 3);
      #2 reset = 1;
      #1 check("async_rst_q", q, 0);
      dir = 1;
      #2 reset = 0;
      step();
      check("post_rst_q1", q, 1);
      step();
      check("post_rst_q2", q, 2);
      en = 0;

      // ---- 5: cascade, 40 clks
      c_en = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         check("casc_val", q2 * 6 + q1, (i + 1) % 36);
         check("casc_wrap2", wrap2, (i == 35) ? 1 : 0);
         check("casc_range", (q1 < 6 && q2 < 6) ? 1 : 0, 1);
      end
      c_en = 0;

      // ---- 6: WIDTH=4, MODULUS=16
      w_load = 1; w_load_val = 4'd14;
      step();
      check("w_ld14", w_q, 14);
      w_load = 0; w_en = 1; w_dir = 1;
      step();
      check("w_q15", w_q, 15);
      check("w_wrap15", w_wrap, 0);
      check("w_tc15", w_tc, 1);
      step();
      check("w_q0", w_q, 0);
      check("w_wrap0", w_wrap, 1);
      step();
      check("w_q1", w_q, 1);
      check("w_wrap1", w_wrap, 0);
      w_en = 0; w_load = 1; w_load_val = 4'd15;
      step();
      check("w_ld15_q", w_q, 15);
      check("w_ld15_err", w_load_err, 0);
      w_load = 0; w_clr = 1;
      step();
      w_clr = 0; w_en = 1; w_dir = 0;
      step();
      check("w_dn_q", w_q, 15);
      check("w_dn_wrap", w_wrap, 1);
      w_en = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
